// File: rtl/sp_ram_arb_pkg.sv
// ============================================================================
// Module   : sp_ram_arb_pkg
// Brief    : Shared types and constants for the single-port RAM arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sp_ram_arb_pkg;

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} arb_state_t;

   localparam int NUM_REQ = 2;
   localparam int STAT_W  = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sp_ram_rr_grant.sv
// ============================================================================
// Module   : sp_ram_rr_grant
// Brief    : Two-way round-robin grant; rr_ptr picks the winner on contention.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sp_ram_rr_grant
   import sp_ram_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               rr_ptr,
   output logic [NUM_REQ-1:0] grant
);

   always_comb begin
      grant = req_valid;
      if (&req_valid) begin
         grant = rr_ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
// ============================================================================
// Module   : sp_ram_arbiter
// Brief    : Round-robin sharing of one single-port RAM between two requesters,
//            with zero-fill after reset. Optional statistics counters are
//            enabled by defining SP_RAM_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sp_ram_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  init_done,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_data_in,
   output logic                  mem_write_en,
   input  logic [DATA_W-1:0]     mem_data_out
`ifdef SP_RAM_ARB_STATS_EN
  ,output logic [2*STAT_W-1:0]   stat_grants
  ,output logic [STAT_W-1:0]     stat_conflicts
`endif
);

   localparam logic [ADDR_W-1:0] c_CLR_LAST = '1;

   arb_state_t          r_state;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic                r_rr_ptr;
   logic                r_rd_vld;
   logic                r_rd_tag;
   logic [ADDR_W-1:0]   r_last_addr;
   logic [DATA_W-1:0]   r_last_data;

   logic                w_run;
   logic [NUM_REQ-1:0]  w_grant;
   logic                w_xfer;
   logic                w_gnt_idx;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   assign w_run = (r_state == ST_RUN);

   sp_ram_rr_grant u_grant (
      .req_valid (req_valid & {NUM_REQ{w_run}}),
      .rr_ptr    (r_rr_ptr),
      .grant     (w_grant)
   );

   assign w_xfer      = |w_grant;
   assign w_gnt_idx   = w_grant[1];
   assign w_sel_addr  = w_gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
   assign w_sel_wdata = w_gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

   assign req_ready = w_grant;
   assign init_done = w_run;
   assign rsp_valid = {r_rd_vld & r_rd_tag, r_rd_vld & ~r_rd_tag};
   assign rsp_data  = mem_data_out;

   // Idle cycles replay the last address/data so the RAM pins never glitch.
   always_comb begin
      mem_addr     = r_last_addr;
      mem_data_in  = r_last_data;
      mem_write_en = 1'b0;
      if (r_state == ST_CLEAR) begin
         mem_addr     = r_clr_cnt;
         mem_data_in  = '0;
         mem_write_en = rst_n;
      end else if (w_xfer) begin
         mem_addr     = w_sel_addr;
         mem_data_in  = w_sel_wdata;
         mem_write_en = req_wr[w_gnt_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_CLEAR;
         r_clr_cnt   <= '0;
         r_rr_ptr    <= 1'b0;
         r_rd_vld    <= 1'b0;
         r_rd_tag    <= 1'b0;
         r_last_addr <= '0;
         r_last_data <= '0;
      end else begin
         r_rd_vld <= 1'b0;
         case (r_state)
            ST_CLEAR: begin
               r_clr_cnt   <= r_clr_cnt + 1'b1;
               r_last_addr <= r_clr_cnt;
               r_last_data <= '0;
               if (r_clr_cnt == c_CLR_LAST) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_xfer) begin
                  r_rr_ptr    <= ~w_gnt_idx;
                  r_last_addr <= w_sel_addr;
                  r_last_data <= w_sel_wdata;
                  r_rd_vld    <= ~req_wr[w_gnt_idx];
                  r_rd_tag    <= w_gnt_idx;
               end
            end
            default: r_state <= ST_CLEAR;
         endcase
      end
   end

`ifdef SP_RAM_ARB_STATS_EN
   logic [STAT_W-1:0] r_grants0;
   logic [STAT_W-1:0] r_grants1;
   logic [STAT_W-1:0] r_conflicts;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_grants0   <= '0;
         r_grants1   <= '0;
         r_conflicts <= '0;
      end else if (w_run) begin
         if (w_grant[0]) r_grants0 <= sat_inc(r_grants0);
         if (w_grant[1]) r_grants1 <= sat_inc(r_grants1);
         if (&req_valid) r_conflicts <= sat_inc(r_conflicts);
      end
   end

   assign stat_grants    = {r_grants1, r_grants0};
   assign stat_conflicts = r_conflicts;
`endif

endmodule

`default_nettype wire
